mem_wb: RTL and testbench

MEM_WB -- requirements
Module: mem_wb

---
 rtl/mem_wb_pkg.sv | 17 +
 rtl/load_align.sv | 50 +++++
 rtl/mem_wb.sv | 88 ++++++++
 tb/tb_mem_wb.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_pkg.sv
// Shared defines for the MEM/WB stage: load-type codes and enable polarities.
package mem_wb_pkg;

    // Load-type encoding driven by the MEM stage; codes 5-7 are reserved.
    typedef enum logic [2:0] {
        LdLb  = 3'd0,
        LdLbu = 3'd1,
        LdLh  = 3'd2,
        LdLhu = 3'd3,
        LdLw  = 3'd4
    } load_type_e;

    // Active level of the register-file write enable and of the load request.
    localparam logic Enable_write = 1'b1;
    localparam logic Enable_read  = 1'b1;

endpackage

// File: rtl/load_align.sv
// Load-data extraction, sign/zero extension and misalignment/reserved-type detection.
module load_align
    import mem_wb_pkg::*;
(
    input  logic [2:0]  load_type,
    input  logic [1:0]  addr_low,
    input  logic [31:0] rdata,
    output logic [31:0] data,
    output logic        fault
);

    load_type_e  lt;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign lt = load_type_e'(load_type);

    // Pick the addressed little-endian lane, then extend or flag a fault.
    always_comb begin
        byte_sel = 8'h00;
        case (addr_low)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr_low[1] ? rdata[31:16] : rdata[15:0];

        data  = 32'h0000_0000;
        fault = 1'b0;
        case (lt)
            LdLb:  data = {{24{byte_sel[7]}}, byte_sel};
            LdLbu: data = {24'h00_0000, byte_sel};
            LdLh: begin
                if (addr_low[0]) fault = 1'b1;
                else             data  = {{16{half_sel[15]}}, half_sel};
            end
            LdLhu: begin
                if (addr_low[0]) fault = 1'b1;
                else             data  = {16'h0000, half_sel};
            end
            LdLw: begin
                if (addr_low != 2'd0) fault = 1'b1;
                else                  data  = rdata;
            end
            default: fault = 1'b1;
        endcase
    end

endmodule

// File: rtl/mem_wb.sv
// MEM/WB pipeline register: selects ALU or aligned load data, drives the regfile write port,
// keeps a sticky load-fault flag and a retired-instruction counter.
module mem_wb
    import mem_wb_pkg::*;
#(
    parameter logic [31:0] RESET_PC_TAG = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        mem_wreg,
    input  logic [4:0]  mem_waddr,
    input  logic [31:0] mem_wdata,
    input  logic        mem_is_load,
    input  logic [2:0]  mem_load_type,
    input  logic [1:0]  mem_addr_low,
    input  logic [31:0] mem_rdata,
    input  logic        stall,
    input  logic        flush,
    output logic        wb_ena,
    output logic [4:0]  wb_waddr,
    output logic [31:0] wb_wdata,
    output logic        load_err,
    output logic [31:0] retired
);

    logic [31:0] ld_data;
    logic        ld_fault;
    logic        cap_fault;
    logic [31:0] cap_data;
    logic        cap_ena;

    logic        wb_ena_q;
    logic [4:0]  wb_waddr_q;
    logic [31:0] wb_wdata_q;
    logic        load_err_q;
    logic [31:0] retired_q;

    load_align u_load_align (
        .load_type (mem_load_type),
        .addr_low  (mem_addr_low),
        .rdata     (mem_rdata),
        .data      (ld_data),
        .fault     (ld_fault)
    );

    // Align results only matter for loads; a fault zeroes the data and blocks the write.
    always_comb begin
        cap_fault = (mem_is_load == Enable_read) && ld_fault;
        cap_data  = 32'h0000_0000;
        if (!cap_fault) cap_data = (mem_is_load == Enable_read) ? ld_data : mem_wdata;
        cap_ena   = (mem_wreg && (mem_waddr != 5'd0) && !cap_fault) ? Enable_write : ~Enable_write;
    end

    // WB register: reset beats flush, flush beats stall, stall holds everything.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wb_ena_q   <= ~Enable_write;
            wb_waddr_q <= 5'd0;
            wb_wdata_q <= 32'h0000_0000;
            load_err_q <= 1'b0;
            retired_q  <= RESET_PC_TAG;
        end else if (flush) begin
            wb_ena_q   <= ~Enable_write;
            wb_waddr_q <= 5'd0;
            wb_wdata_q <= 32'h0000_0000;
        end else if (!stall) begin
            if (in_valid) begin
                wb_ena_q   <= cap_ena;
                wb_waddr_q <= mem_waddr;
                wb_wdata_q <= cap_data;
                retired_q  <= retired_q + 32'd1;
                if (cap_fault) load_err_q <= 1'b1;
            end else begin
                wb_ena_q   <= ~Enable_write;
                wb_waddr_q <= 5'd0;
                wb_wdata_q <= 32'h0000_0000;
            end
        end
    end

    assign wb_ena   = wb_ena_q;
    assign wb_waddr = wb_waddr_q;
    assign wb_wdata = wb_wdata_q;
    assign load_err = load_err_q;
    assign retired  = retired_q;

endmodule

// File: tb/tb_mem_wb.sv
// Directed testbench for mem_wb; a second instance checks the retired-counter wrap.
module tb_mem_wb;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        mem_wreg;
    logic [4:0]  mem_waddr;
    logic [31:0] mem_wdata;
    logic        mem_is_load;
    logic [2:0]  mem_load_type;
    logic [1:0]  mem_addr_low;
    logic [31:0] mem_rdata;
    logic        stall;
    logic        flush;

    logic        wb_ena, w_wb_ena;
    logic [4:0]  wb_waddr, w_wb_waddr;
    logic [31:0] wb_wdata, w_wb_wdata;
    logic        load_err, w_load_err;
    logic [31:0] retired, w_retired;

    logic [70:0] obs;
    int checks = 0;
    int errors = 0;

    assign obs = {wb_ena, wb_waddr, wb_wdata, load_err, retired};

    always #5 clk = ~clk;

    mem_wb dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .mem_wreg(mem_wreg),
        .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_is_load(mem_is_load),
        .mem_load_type(mem_load_type), .mem_addr_low(mem_addr_low), .mem_rdata(mem_rdata),
        .stall(stall), .flush(flush), .wb_ena(wb_ena), .wb_waddr(wb_waddr),
        .wb_wdata(wb_wdata), .load_err(load_err), .retired(retired)
    );

    mem_wb #(.RESET_PC_TAG(32'hFFFF_FFFF)) dut_wrap (
        .clk(clk), .rst(rst), .in_valid(in_valid), .mem_wreg(mem_wreg),
        .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_is_load(mem_is_load),
        .mem_load_type(mem_load_type), .mem_addr_low(mem_addr_low), .mem_rdata(mem_rdata),
        .stall(stall), .flush(flush), .wb_ena(w_wb_ena), .wb_waddr(w_wb_waddr),
        .wb_wdata(w_wb_wdata), .load_err(w_load_err), .retired(w_retired)
    );

    task automatic drive(input logic v, input logic wreg, input logic [4:0] wa,
                         input logic [31:0] wd, input logic ld, input logic [2:0] lt,
                         input logic [1:0] al);
        in_valid      = v;
        mem_wreg      = wreg;
        mem_waddr     = wa;
        mem_wdata     = wd;
        mem_is_load   = ld;
        mem_load_type = lt;
        mem_addr_low  = al;
    endtask

    // Advance one edge and settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; stall = 1'b0; flush = 1'b0; mem_rdata = 32'h0;
        drive(1'b1, 1'b1, 5'd3, 32'hDEAD_BEEF, 1'b0, 3'd0, 2'd0);
        step();
        checks++;
        if (obs !== {1'b0, 5'd0, 32'h0, 1'b0, 32'h0}) begin
            errors++; $display("FAIL reset got %h exp %h", obs, {1'b0, 5'd0, 32'h0, 1'b0, 32'h0});
        end
        checks++;
        if (w_retired !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL reset_tag got %h exp %h", w_retired, 32'hFFFF_FFFF);
        end
    endtask

    task automatic test_alu_write();
        rst = 1'b1;
        drive(1'b1, 1'b1, 5'd5, 32'h1234_5678, 1'b0, 3'd0, 2'd0);
        step();
        checks++;
        if (obs !== {1'b1, 5'd5, 32'h1234_5678, 1'b0, 32'd1}) begin
            errors++; $display("FAIL alu_write got %h exp %h", obs,
                               {1'b1, 5'd5, 32'h1234_5678, 1'b0, 32'd1});
        end
        checks++;
        if (w_retired !== 32'h0) begin
            errors++; $display("FAIL retired_wrap got %h exp %h", w_retired, 32'h0);
        end
        drive(1'b0, 1'b1, 5'd5, 32'h1234_5678, 1'b0, 3'd0, 2'd0);
        step();
        checks++;
        if (obs !== {1'b0, 5'd0, 32'h0, 1'b0, 32'd1}) begin
            errors++; $display("FAIL idle got %h exp %h", obs, {1'b0, 5'd0, 32'h0, 1'b0, 32'd1});
        end
    endtask

    task automatic test_loads();
        logic [2:0]  lt  [4] = '{3'd0, 3'd1, 3'd2, 3'd3};
        logic [1:0]  al  [4] = '{2'd3, 2'd0, 2'd2, 2'd0};
        logic [31:0] exp [4] = '{32'hFFFF_FF80, 32'h0000_0081, 32'hFFFF_80FF, 32'h0000_7F81};
        mem_rdata = 32'h80FF_7F81;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 5'd7, 32'hAAAA_AAAA, 1'b1, lt[i], al[i]);
            step();
            checks++;
            if (obs !== {1'b1, 5'd7, exp[i], 1'b0, 32'(2 + i)}) begin
                errors++; $display("FAIL load%0d got %h exp %h", i, obs,
                                   {1'b1, 5'd7, exp[i], 1'b0, 32'(2 + i)});
            end
        end
        // Non-load with a reserved type and odd address must pass ALU data untouched.
        drive(1'b1, 1'b1, 5'd8, 32'h0BAD_F00D, 1'b0, 3'd7, 2'd3);
        step();
        checks++;
        if (obs !== {1'b1, 5'd8, 32'h0BAD_F00D, 1'b0, 32'd6}) begin
            errors++; $display("FAIL nonload_ignore got %h exp %h", obs,
                               {1'b1, 5'd8, 32'h0BAD_F00D, 1'b0, 32'd6});
        end
    endtask

    task automatic test_waddr_zero();
        drive(1'b1, 1'b1, 5'd0, 32'h1111_2222, 1'b0, 3'd0, 2'd0);
        step();
        checks++;
        if (obs !== {1'b0, 5'd0, 32'h1111_2222, 1'b0, 32'd7}) begin
            errors++; $display("FAIL waddr_zero got %h exp %h", obs,
                               {1'b0, 5'd0, 32'h1111_2222, 1'b0, 32'd7});
        end
    endtask

    task automatic test_stall_flush();
        drive(1'b1, 1'b1, 5'd9, 32'h0000_0055, 1'b0, 3'd0, 2'd0);
        step();
        stall = 1'b1;
        drive(1'b1, 1'b1, 5'd3, 32'h0000_0099, 1'b0, 3'd0, 2'd0);
        step();
        step();
        checks++;
        if (obs !== {1'b1, 5'd9, 32'h0000_0055, 1'b0, 32'd8}) begin
            errors++; $display("FAIL stall_hold got %h exp %h", obs,
                               {1'b1, 5'd9, 32'h0000_0055, 1'b0, 32'd8});
        end
        flush = 1'b1;
        step();
        checks++;
        if ({wb_ena, retired} !== {1'b0, 32'd8}) begin
            errors++; $display("FAIL flush_stall got %h exp %h", {wb_ena, retired}, {1'b0, 32'd8});
        end
        stall = 1'b0; flush = 1'b0;
    endtask

    task automatic test_fault();
        mem_rdata = 32'h80FF_7F81;
        drive(1'b1, 1'b1, 5'd4, 32'h0, 1'b1, 3'd4, 2'd2);
        step();
        checks++;
        if ({wb_ena, wb_wdata, load_err, retired} !== {1'b0, 32'h0, 1'b1, 32'd9}) begin
            errors++; $display("FAIL lw_fault got %h exp %h", {wb_ena, wb_wdata, load_err, retired},
                               {1'b0, 32'h0, 1'b1, 32'd9});
        end
        drive(1'b1, 1'b1, 5'd6, 32'h0000_0077, 1'b0, 3'd0, 2'd0);
        step();
        checks++;
        if (obs !== {1'b1, 5'd6, 32'h0000_0077, 1'b1, 32'd10}) begin
            errors++; $display("FAIL err_sticky got %h exp %h", obs,
                               {1'b1, 5'd6, 32'h0000_0077, 1'b1, 32'd10});
        end
        drive(1'b1, 1'b1, 5'd2, 32'h0, 1'b1, 3'd3, 2'd1);
        step();
        checks++;
        if ({wb_ena, wb_wdata, load_err, retired} !== {1'b0, 32'h0, 1'b1, 32'd11}) begin
            errors++; $display("FAIL lhu_fault got %h exp %h",
                               {wb_ena, wb_wdata, load_err, retired}, {1'b0, 32'h0, 1'b1, 32'd11});
        end
        drive(1'b1, 1'b1, 5'd2, 32'h0, 1'b1, 3'd5, 2'd0);
        step();
        checks++;
        if ({wb_ena, wb_wdata, load_err, retired} !== {1'b0, 32'h0, 1'b1, 32'd12}) begin
            errors++; $display("FAIL rsv_fault got %h exp %h",
                               {wb_ena, wb_wdata, load_err, retired}, {1'b0, 32'h0, 1'b1, 32'd12});
        end
    endtask

    task automatic test_reset_mid();
        rst = 1'b0; stall = 1'b1; flush = 1'b1;
        drive(1'b1, 1'b1, 5'd12, 32'hCAFE_0001, 1'b0, 3'd0, 2'd0);
        step();
        checks++;
        if (obs !== {1'b0, 5'd0, 32'h0, 1'b0, 32'h0}) begin
            errors++; $display("FAIL reset_mid got %h exp %h", obs, {1'b0, 5'd0, 32'h0, 1'b0, 32'h0});
        end
        checks++;
        if (w_retired !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL reset_mid_tag got %h exp %h", w_retired, 32'hFFFF_FFFF);
        end
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        drive(1'b1, 1'b1, 5'd1, 32'h0000_0042, 1'b0, 3'd0, 2'd0);
        step();
        checks++;
        if (obs !== {1'b1, 5'd1, 32'h0000_0042, 1'b0, 32'd1}) begin
            errors++; $display("FAIL post_reset got %h exp %h", obs,
                               {1'b1, 5'd1, 32'h0000_0042, 1'b0, 32'd1});
        end
    endtask

    initial begin
        test_reset();
        test_alu_write();
        test_loads();
        test_waddr_zero();
        test_stall_flush();
        test_fault();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
